// File: rtl/shift_add_mult4.sv
// rtl/shift_add_mult4.sv - 4x4 unsigned shift-and-add multiplier around a 4-bit ripple-carry adder
// The rca4 adder is kept as its own module so the multiplier only steers its operands.

module rca4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   assign carry[0] = cin;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_bit
         assign sum[i]     = x[i] ^ y[i] ^ carry[i];
         assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
      end
   endgenerate

   assign cout = carry[4];

endmodule

module shift_add_mult4 (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [3:0] mcand;
   logic [3:0] hi;
   logic [3:0] lo;
   logic [1:0] cnt;

   logic [3:0] add_b;
   logic [3:0] sum;
   logic       cout;
   logic       load;
   logic       last_iter;

   assign add_b = lo[0] ? mcand : 4'b0000;

   rca4 u_adder (
      .x    (hi),
      .y    (add_b),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // A new multiply may be accepted from IDLE or straight out of DONE.
   assign load      = start && ((state == IDLE) || (state == DONE));
   assign last_iter = (state == RUN) && (cnt == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = start ? RUN : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand   <= 4'd0;
         hi      <= 4'd0;
         lo      <= 4'd0;
         cnt     <= 2'd0;
         product <= 8'd0;
      end else if (load) begin
         mcand <= a;
         lo    <= b;
         hi    <= 4'd0;
         cnt   <= 2'd0;
      end else if (state == RUN) begin
         // Adder carry-out becomes the new top bit of the accumulator.
         hi  <= {cout, sum[3:1]};
         lo  <= {sum[0], lo[3:1]};
         cnt <= cnt + 2'd1;
         if (last_iter) begin
            product <= {cout, sum, lo[3:1]};
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult4.sv
// tb/tb_shift_add_mult4.sv - randomized self-checking bench for shift_add_mult4
// Expected products come from plain a*b; cycle expectations from the documented latency.

module tb_shift_add_mult4;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int         n_vec;
   int         n_err;
   logic [7:0] last_p;

   shift_add_mult4 dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mult(input logic [3:0] x, input logic [3:0] y);
      int p;
      p = int'(x) * int'(y);
      return p[7:0];
   endfunction

   // Accept x*y, optionally poking start with 0xF operands mid-RUN, and check every cycle.
   task automatic run_mult(input logic [3:0] x, input logic [3:0] y, input bit poke);
      @(negedge clk);
      check("idle_done", {7'd0, done}, 8'd0);
      check("idle_busy", {7'd0, busy}, 8'd0);
      start = 1'b1;
      a = x;
      b = y;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         start = poke && (i == 1);
         a = poke ? 4'hF : 4'($urandom);
         b = poke ? 4'hF : 4'($urandom);
         check("run_busy", {7'd0, busy}, 8'd1);
         check("run_done", {7'd0, done}, 8'd0);
         check("run_hold", product, last_p);
         @(negedge clk);
      end
      start = 1'b0;
      last_p = ref_mult(x, y);
      check("done_pulse", {7'd0, done}, 8'd1);
      check("done_busy", {7'd0, busy}, 8'd0);
      check("product", product, last_p);
   endtask

   // Two multiplies with start held high through the first DONE cycle.
   task automatic run_b2b(input logic [3:0] x1, input logic [3:0] y1,
                          input logic [3:0] x2, input logic [3:0] y2);
      @(negedge clk);
      start = 1'b1;
      a = x1;
      b = y1;
      @(negedge clk);
      a = x2;
      b = y2;
      for (int i = 0; i < 4; i++) begin
         check("b2b_busy1", {7'd0, busy}, 8'd1);
         @(negedge clk);
      end
      last_p = ref_mult(x1, y1);
      check("b2b_done1", {7'd0, done}, 8'd1);
      check("b2b_prod1", product, last_p);
      @(negedge clk);
      start = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         check("b2b_busy2", {7'd0, busy}, 8'd1);
         check("b2b_hold", product, last_p);
         @(negedge clk);
      end
      last_p = ref_mult(x2, y2);
      check("b2b_done2", {7'd0, done}, 8'd1);
      check("b2b_prod2", product, last_p);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      last_p = 8'd0;
      reset  = 1'b1;
      start  = 1'b0;
      a      = 4'd0;
      b      = 4'd0;
      #1;
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_product", product, 8'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_mult(4'h0, 4'hF, 1'b0);
      run_mult(4'hF, 4'hF, 1'b0);
      run_mult(4'hD, 4'hB, 1'b0);
      run_mult(4'h1, 4'h8, 1'b0);
      run_mult(4'h3, 4'h5, 1'b1);
      @(negedge clk);
      check("poke_no_rerun", {7'd0, busy}, 8'd0);
      check("poke_single_done", {7'd0, done}, 8'd0);

      run_b2b(4'h7, 4'h6, 4'h2, 4'h9);

      for (int n = 0; n < 24; n++) begin
         run_mult(4'($urandom), 4'($urandom), 1'($urandom));
      end

      // Abort mid-RUN: outputs must clear before any clock edge.
      run_mult(4'hE, 4'hB, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a = 4'h9;
      b = 4'h7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", {7'd0, busy}, 8'd0);
      check("abort_done", {7'd0, done}, 8'd0);
      check("abort_product", product, 8'd0);
      last_p = 8'd0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_abort_busy", {7'd0, busy}, 8'd0);
         check("post_abort_done", {7'd0, done}, 8'd0);
         check("post_abort_prod", product, 8'd0);
      end
      run_mult(4'h4, 4'h4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_add_mult4.md
# shift_add_mult4

Sequential 4×4 unsigned multiplier built around the team's 4-bit ripple-carry adder: the adder is instantiated inside this block with carry-in tied to 0. Each cycle this block supplies the adder's operands and consumes its `sum` and `cout` to perform one shift-and-add iteration. It takes a start pulse with two 4-bit operands and returns an 8-bit product after a fixed number of cycles, together with a one-cycle `done` pulse. It is the datapath stage that sits directly downstream of the adder.

## Interface
- No parameters. Operand width is fixed at 4 bits and product width at 8 bits.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `start`  in  1  Request to begin a multiply. Sampled on the rising edge of `clk`.
- `a`  in  4  Multiplicand, unsigned. Captured when `start` is accepted.
- `b`  in  4  Multiplier, unsigned. Captured when `start` is accepted.
- `busy`  out  1  High while an iteration sequence is in progress (state RUN).
- `done`  out  1  One-cycle pulse marking that `product` has just been updated.
- `product`  out  8  Registered result `a*b`. Holds its value until the next completion.

## Operation
- **Internal registers**
  - `mcand[3:0]`: holds the multiplicand.
  - `hi[3:0]`: accumulator.
  - `lo[3:0]`: holds the multiplier, shifted out one bit per iteration.
  - `cnt[1:0]`: iteration counter.
  - `state`: one of IDLE, RUN, DONE.
- **Adder connection**
  - Operand A is `hi`.
  - Operand B is `lo[0] ? mcand : 4'b0000`.
  - Carry-in is 0.
- **IDLE**
  - If `start`=1: load `mcand`←`a`, `lo`←`b`, `hi`←0, `cnt`←0, then go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - Shift the concatenation `{cout, sum, lo}` right by one: `hi`←`{cout, sum[3:1]}`, `lo`←`{sum[0], lo[3:1]}`.
  - Increment `cnt`.
  - On the iteration where `cnt`==3: `product`←`{cout, sum, lo[3:1]}`, i.e. the final shifted `{hi,lo}`. Then go to DONE.
  - `start` is ignored in RUN, and `a`/`b` are not resampled.
- **DONE** (lasts one cycle)
  - `done`=1.
  - If `start`=1: accept the new operands exactly as IDLE does and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- **Arithmetic**
  - Unsigned only.
  - The 8-bit product cannot overflow; the maximum is 15×15 = 225 = 0xE1.
  - `cout` of the adder is never discarded: it becomes `hi[3]`.
- **Reset** (asynchronous, any state including mid-RUN)
  - state←IDLE, `busy`=0, `done`=0, `product`=0x00.
  - `mcand`, `hi`, `lo` and `cnt` all ←0.
  - An in-flight multiply is aborted with no `done`.

## Timing
- `busy` and `done` are decoded from registered state: `busy` = (state==RUN), `done` = (state==DONE). Neither has a combinational path from `start`.
- **Latency.** `start` is accepted at edge k.
  - `busy`=1 for cycles k..k+3.
  - Iterations happen at edges k+1..k+4.
  - `product` is updated at edge k+4.
  - `done`=1 for the single cycle following edge k+4.
  - Start-to-done latency is therefore 5 edges.
- **Throughput.** With `start` held high, a new multiply is accepted at every DONE edge. That gives one result per 5 cycles.
- `product` is stable from the edge where `done` rises until the next completion or reset.
- Operands only need to be valid in the cycle in which `start` is accepted.

## Test plan
- **Zero operand.** Reset, then `start` with a=0x0, b=0xF → `busy` high for 4 cycles, `done` pulses 5 edges after start, `product`=0x00.
- **Maximum operands.** a=0xF, b=0xF → `product`=0xE1 (225). Confirms the adder `cout` propagates into `hi[3]`.
- **Mixed operands.** a=0xD, b=0xB → `product`=0x8F (143). A second run with a=0x1, b=0x8 → `product`=0x08.
- **Start ignored while busy.** a=0x3, b=0x5, then pulse `start` with a=0xF, b=0xF during RUN → `product`=0x0F. Only one `done` pulse occurs, and the second operand pair is never used.
- **Back-to-back.** Hold `start` high with a=0x7, b=0x6 then a=0x2, b=0x9 → `done` pulses 5 cycles apart, giving `product`=0x2A then 0x12.
- **Reset mid-operation.** Assert `reset` two cycles into RUN → `busy`, `done` and `product` go to 0 immediately, without waiting for a clock edge. After `reset` is released the block sits in IDLE, and a fresh a=0x4, b=0x4 yields `product`=0x10.
